// File: rtl/vec_alu_pkg.sv
// Shared definitions for the handshaked vector ALU: opcodes, FSM states and
// the fp16 add/multiply functions used by every lane.
package vec_alu_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_EW    = 16;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_SST  = 4'b0011;
  localparam logic [3:0] OP_VLD  = 4'b0100;
  localparam logic [3:0] OP_VST  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLH  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic {ST_IDLE, ST_DOT} state_t;

  // m carries the significand with unit weight at bit 30 and e is the biased
  // exponent; normalises, handles underflow to denormal and rounds to nearest even.
  function automatic logic [15:0] round_pack(input logic s, input int e_in,
                                             input logic [31:0] m_in, input logic stk_in);
    logic [31:0] m;
    logic [11:0] mr;
    logic        stk;
    logic        g;
    logic        st;
    int          e;
    int          sh;
    m   = m_in;
    e   = e_in;
    stk = stk_in;
    if (m == 32'd0) return {s, 15'd0};
    if (m[31]) begin
      stk = stk | m[0];
      m   = m >> 1;
      e   = e + 1;
    end
    for (int i = 0; i < 31; i++) begin
      if (!m[30] && e > 1) begin
        m = m << 1;
        e = e - 1;
      end
    end
    if (e < 1) begin
      sh = 1 - e;
      for (int i = 0; i < 32; i++) begin
        if (i < sh) begin
          stk = stk | m[0];
          m   = m >> 1;
        end
      end
      e = 1;
    end
    g  = m[19];
    st = stk | (|m[18:0]);
    mr = {1'b0, m[30:20]} + 12'(g & (st | m[20]));
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'd0};
    return {s, (mr[10] ? 5'(e) : 5'd0), mr[9:0]};
  endfunction

  function automatic logic [15:0] float_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [10:0] ma;
    logic [10:0] mb;
    logic [21:0] p;
    int          ea;
    int          eb;
    s = a[15] ^ b[15];
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
      return 16'h7E00;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F)
      return (a[14:0] == 15'd0 || b[14:0] == 15'd0) ? 16'h7E00 : {s, 5'h1F, 10'd0};
    ma = {a[14:10] != 5'd0, a[9:0]};
    mb = {b[14:10] != 5'd0, b[9:0]};
    ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
    p  = 22'(ma) * 22'(mb);
    return round_pack(s, ea + eb - 15, {p, 10'd0}, 1'b0);
  endfunction

  function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] mx;
    logic [31:0] my;
    logic [31:0] m;
    logic        stk;
    logic        s;
    int          ex;
    int          ey;
    int          d;
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
      return 16'h7E00;
    if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15]) return 16'h7E00;
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    if (b[14:0] > a[14:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    ex  = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
    ey  = (y[14:10] == 5'd0) ? 1 : int'(y[14:10]);
    mx  = {1'b0, x[14:10] != 5'd0, x[9:0], 20'd0};
    my  = {1'b0, y[14:10] != 5'd0, y[9:0], 20'd0};
    d   = ex - ey;
    stk = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < d) begin
        stk = stk | my[0];
        my  = my >> 1;
      end
    end
    // Folding the lost bits into the LSB keeps subtraction rounding exact.
    my[0] = my[0] | stk;
    if (x[15] == y[15]) begin
      m = mx + my;
      s = x[15];
    end else begin
      m = mx - my;
      s = (m == 32'd0) ? 1'b0 : x[15];
    end
    return round_pack(s, ex, m, 1'b0);
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One fp16 lane: product or sum; with i_acc_en the adder accumulates the
// lane product into i_acc instead of adding the raw operands.
module vec_alu_lane
  import vec_alu_pkg::*;
(
  input  logic        i_mul,
  input  logic        i_acc_en,
  input  logic [15:0] i_acc,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);

  logic [15:0] w_prod;
  logic [15:0] w_sum;

  always_comb begin
    w_prod = float_mul(i_a, i_b);
    w_sum  = i_acc_en ? float_add(i_acc, w_prod) : float_add(i_a, i_b);
    o_y    = i_mul ? w_prod : w_sum;
  end

endmodule

// File: rtl/vec_alu_hs.sv
// Handshaked fp16 vector ALU: single-cycle VADD/SMUL, LANES-cycle VDOT
// reduction on lane 0, one-deep output register held under backpressure.
module vec_alu_hs
  import vec_alu_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int EW    = DEF_EW,
  localparam int VW    = LANES * EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [VW-1:0] op_1,
  input  logic [VW-1:0] op_2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] result,
  output logic          illegal_op
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_out_valid;
  logic [VW-1:0]   r_result;
  logic            r_illegal;
  logic [KW-1:0]   r_k;
  logic [EW-1:0]   r_acc;
  logic [VW-1:0]   r_a;
  logic [VW-1:0]   r_b;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_dot;
  logic            w_is_mul;
  logic            w_last;
  logic [EW-1:0]   w_da;
  logic [EW-1:0]   w_db;
  logic [EW-1:0]   w_la [LANES];
  logic [EW-1:0]   w_lb [LANES];
  logic [EW-1:0]   w_ly [LANES];
  logic [VW-1:0]   w_vec;

  always_comb begin
    w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    w_accept   = in_valid && w_in_ready;
    w_dot      = (r_state == ST_DOT);
    w_is_mul   = (opcode == OP_SMUL);
    w_last     = (r_k == KW'(LANES - 1));
    w_da       = '0;
    w_db       = '0;
    for (int i = 0; i < LANES; i++) begin
      if (KW'(i) == r_k) begin
        w_da = r_a[i*EW +: EW];
        w_db = r_b[i*EW +: EW];
      end
    end
  end

  // SMUL broadcasts op_1 lane 0; lane 0 walks the latched operands during VDOT.
  always_comb begin
    w_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      w_la[i] = w_is_mul ? op_1[0 +: EW] : op_1[i*EW +: EW];
      w_lb[i] = op_2[i*EW +: EW];
      w_vec[i*EW +: EW] = w_ly[i];
    end
    if (w_dot) begin
      w_la[0] = w_da;
      w_lb[0] = w_db;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane u_lane (
      .i_mul    (w_is_mul && !(g == 0 && w_dot)),
      .i_acc_en ((g == 0) && w_dot),
      .i_acc    ((g == 0) ? r_acc : '0),
      .i_a      (w_la[g]),
      .i_b      (w_lb[g]),
      .o_y      (w_ly[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && opcode == OP_VDOT) w_state_nxt = ST_DOT;
      ST_DOT:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_k         <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_dot) begin
        r_acc <= w_ly[0];
        r_k   <= r_k + KW'(1);
        if (w_last) begin
          r_result    <= {{(VW-EW){1'b0}}, w_ly[0]};
          r_out_valid <= 1'b1;
        end
      end else if (w_accept) begin
        case (opcode)
          OP_VADD, OP_SMUL: begin
            r_result    <= w_vec;
            r_out_valid <= 1'b1;
          end
          OP_VDOT: begin
            r_a   <= op_1;
            r_b   <= op_2;
            r_acc <= '0;
            r_k   <= '0;
          end
          OP_NOP:  ;
          default: r_illegal <= 1'b1;
        endcase
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign illegal_op = r_illegal;

endmodule

// File: doc/vec_alu_hs.md
Name: vec_alu_hs

Overview:
- Parametrised, handshaked successor to the single-cycle vector ALU in the vector datapath.
- Operates on LANES half-precision (fp16) lanes. Supports lanewise VADD, scalar-times-vector SMUL, and a multi-cycle VDOT reduction.
- Sits between the register-read stage (valid/ready producer) and the writeback stage (valid/ready consumer).
- Holds one result until the consumer accepts it.

Parameters:
- LANES, 16, number of fp16 lanes; must be ≥2.
- EW, 16, lane element width in bits; fp16 only, fixed by the shared float functions.
- VW, LANES*EW, vector width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the producer is presenting an operation.
- in_ready  out  1  the block accepts an operation this cycle.
- opcode  in  4  operation code; encodings come from the shared package.
- op_1  in  VW  first vector operand; lane i occupies bits [i*EW +: EW].
- op_2  in  VW  second vector operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  VW  result vector.
- illegal_op  out  1  one-cycle pulse when a non-ALU opcode is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid=0; result=0; illegal_op=0; lane counter=0; accumulator=0. Reset asserted during VDOT aborts it with no output.
- States: IDLE, DOT.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new operation may be accepted in the same cycle the old result drains.
- Accept means in_valid && in_ready at a rising edge. Operands and opcode are sampled only at accept.
- VADD (0000): result lane i = float_add(op_1[i], op_2[i]). The registered result appears with out_valid=1 at the accept edge (latency 1).
- SMUL (0010): scalar = op_1 lane 0; result lane i = float_mul(scalar, op_2[i]); latency 1.
- VDOT (0001): on accept, latch op_1 and op_2; acc=0; k=0; go to DOT.
  - In DOT, each edge computes acc = float_add(acc, float_mul(a[k], b[k])) and then k++.
  - Order is strictly lane 0 first; this order is normative for rounding.
  - On the edge where k==LANES-1:
    - result lane 0 = final acc; lanes 1..LANES-1 = 0.
    - out_valid=1.
    - state goes to IDLE.
  - Total: out_valid high after LANES edges following the accept edge. in_ready=0 throughout DOT.
- NOP (1111): accepted; no result produced; out_valid is unchanged.
- SST, VLD, VST, SLL, SLH, J and undefined codes: accepted and dropped; illegal_op=1 for exactly the cycle after accept; out_valid is unchanged.
- Output hold: while out_valid && !out_ready, result and out_valid are frozen.
  - out_valid falls after the edge where out_ready=1, unless a new VADD/SMUL is accepted on that same edge. In that case out_valid stays 1 and result updates.
- out_ready is ignored when out_valid=0.
- A result that completes in DOT with out_valid already high cannot occur, because in_ready gating ensures the output is free.
- Arithmetic: fp16 semantics, rounding, NaN/Inf and denormal handling are exactly those of the shared float_add and float_mul functions. The block adds no extra rounding or saturation.

Decomposition:
- Shared package vec_alu_pkg contains:
  - opcode localparams (VADD..NOP, same 4-bit encodings as the existing ALU).
  - state encoding (IDLE, DOT).
  - default LANES and EW.
- float_add and float_mul stay in the shared functions include.
- One sub-module: vec_alu_lane, a combinational fp16 add/mul selector (mode bit, a, b -> y).
  - LANES instances are generated for VADD/SMUL.
  - Instance 0's multiplier is reused for VDOT, with the adder fed the acc.

Test Plan:
- Reset and idle: rst pulse mid-cycle -> out_valid=0, result=0, in_ready=1 immediately, with no clk edge needed.
- VADD: all lanes 3C00+3C00, out_ready=1 -> one cycle later out_valid=1, every lane 4000; in_ready remains 1; back-to-back VADD issues produce a result every cycle.
- SMUL: op_1 lane0=4000, op_2 all lanes 4200 -> every lane 4600; op_1 lanes 1..15 are random and must not affect the result.
- VDOT: op_1 = op_2 = all 3C00 -> in_ready=0 for 16 cycles; then result lane0=4C00, lanes 1..15=0; an in_valid held during DOT is not accepted until DOT completes.
- Backpressure: VADD result held with out_ready=0 for 5 cycles -> result stable, in_ready=0; out_ready=1 with a simultaneous new SMUL -> out_valid stays 1 and result switches to the SMUL value.
- Illegal and abort: opcode 0100 -> illegal_op pulses 1 cycle and out_valid stays 0; VDOT with rst asserted at k=7 -> no output, state IDLE, next VADD correct.
